ffo_scan: RTL and testbench
===========================

FFO_SCAN -- requirements
Module: ffo_scan

Interface
REQ-001 Parameter WIDTH, default 32, width of the searched vector; SHALL be at least 2.
REQ-002 Parameter STEP, default 4, bits examined per scan cycle; SHALL divide WIDTH exactly.
REQ-003 Derived PW = $clog2(WIDTH), width of the position output; NCHUNK = WIDTH/STEP.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a new search; accepted only when ready=1.
REQ-007 b  input  WIDTH  vector to search; sampled on the accept edge.
REQ-008 dir  input  1  0 = scan from index 0 upward; 1 = from index WIDTH-1 downward; sampled with b.
REQ-009 next  input  1  in DONE: continue the search past the reported bit.
REQ-010 ack  input  1  in DONE: release the result and return to IDLE.
REQ-011 ready  output  1  high exactly when the state is IDLE.
REQ-012 done  output  1  high for every cycle the state is DONE.
REQ-013 v  output  1  a set bit was found; valid while done=1.
REQ-014 p  output  PW  absolute index of the found bit; 0 when v=0.

Function
REQ-015 FSM states: IDLE, SCAN, DONE; a one-hot or binary encoding is permitted.
REQ-016 IDLE: start=1 loads the working register W<=b and the direction register D<=dir, sets chunk C to the first chunk in direction D, clears v and p, and moves to SCAN.
REQ-017 SCAN: each cycle examines STEP bits of W in chunk C; priority goes to the bit nearest the scan origin in direction D.
REQ-018 SCAN hit: v<=1, p<=absolute index, C holds, move to DONE.
REQ-019 SCAN miss on a non-final chunk: C advances one chunk in direction D and the state stays in SCAN.
REQ-020 SCAN miss on the final chunk: v<=0, p<=0, move to DONE.
REQ-021 Latency: a hit in the k-th chunk scanned (k=0..NCHUNK-1) raises done at the (k+1)-th edge after the accept edge; an all-zero vector raises done after NCHUNK edges.
REQ-022 DONE with ack=1: move to IDLE; v and p hold their values until the next accept.
REQ-023 DONE with next=1, ack=0 and v=1: clear W[p], move to SCAN, and restart at chunk C, the chunk holding the last hit.
REQ-024 DONE with next=1 and v=0: treated as ack.
REQ-025 next and ack together: ack wins.
REQ-026 DONE with neither next nor ack: hold all outputs indefinitely.
REQ-027 start is ignored outside IDLE; b and dir are ignored outside the accept edge.
REQ-028 ready, done, v and p SHALL be driven from registers or decoded state only, with no combinational path from any input.

Reset
REQ-029 While reset=1, the state is IDLE: ready=1, done=0, v=0, p=0, W=0, D=0, C=0.
REQ-030 Reset asserted mid-SCAN or in DONE aborts the operation immediately; the aborted search produces no done.
REQ-031 The first start after reset deassertion is accepted normally.

Configuration
REQ-032 Macro FFO_SCAN_ABORT_EN defined: adds input port abort (1 bit).
REQ-033 With the macro, abort=1 in SCAN or DONE moves the state to IDLE at the next edge with v<=0 and p<=0, and no done is raised.
REQ-034 With the macro, abort takes priority over next, ack and any scan result; abort in IDLE has no effect.
REQ-035 Macro undefined: no abort port exists, and a search always runs to DONE.

Verification (WIDTH=32, STEP=4)
REQ-036 b=0x0000_0100, dir=0, start -> done at the 3rd edge after accept, v=1, p=8.
REQ-037 b=0x0000_0100, dir=1 -> done at the 6th edge, v=1, p=8.
REQ-038 b=0, dir=0 -> done at the 8th edge, v=0, p=0; ack -> ready=1 on the next edge.
REQ-039 b=0x8000_0005, dir=0: p=0 after 1 edge; next -> p=2 after 1 edge; next -> p=31 after 8 edges; next -> v=0, p=0 after 1 edge.
REQ-040 reset pulsed 2 cycles after accept -> ready=1, done=0, v=0, p=0 immediately, and no done follows.
REQ-041 With FFO_SCAN_ABORT_EN, b=0x8000_0000, dir=0, abort at the 3rd cycle -> IDLE next edge, done never high, v=0.

Source files
------------

// File: rtl/ffo_scan.sv
// ffo_scan: multi-cycle find-first-one search over a WIDTH-bit vector.
//
// A search examines STEP bits per cycle. It starts at index 0 and moves
// upward (dir=0), or starts at index WIDTH-1 and moves downward (dir=1).
// When a search finishes, done stays high until the result is released.
// While done is high, "next" clears the reported bit and continues the
// search from the chunk that held it. "ack" releases the result.
//
// Handshake: a start is accepted on a rising clock edge where start=1 and
// ready=1. b and dir are sampled only on that edge. When done=1, one of
// next or ack is consumed on each edge where it is high, and ack wins over
// next. The outputs ready, done, v and p come only from registers or from
// decoded state.
//
// Optional feature: define FFO_SCAN_ABORT_EN to add the abort input.
// Abort cancels a search in SCAN or DONE and returns to IDLE. No done is
// raised for the cancelled search.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   start      request a new search (accepted when ready=1)
//   b          vector to search
//   dir        scan direction (0 = upward from 0, 1 = downward from WIDTH-1)
//   next       in DONE: clear the found bit and keep searching
//   ack        in DONE: release the result and return to IDLE
//   abort      (FFO_SCAN_ABORT_EN only) cancel the current search
//   ready      state is IDLE
//   done       state is DONE
//   v          a set bit was found
//   p          absolute index of the found bit (0 when v=0)
//   state_dbg  current FSM state: 0=IDLE, 1=SCAN, 2=DONE
module ffo_scan #(
    parameter  int WIDTH  = 32,
    parameter  int STEP   = 4,
    localparam int PW     = $clog2(WIDTH),
    localparam int NCHUNK = WIDTH / STEP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] b,
    input  logic             dir,
    input  logic             next,
    input  logic             ack,
`ifdef FFO_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             done,
    output logic             v,
    output logic [PW-1:0]    p,
    output logic [1:0]       state_dbg
);

    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] w_q;
    logic             d_q;
    logic [CW-1:0]    c_q;
    logic             v_q;
    logic [PW-1:0]    p_q;

    // Evaluation of the current chunk
    int               base;
    int               off;
    logic [STEP-1:0]  chunk_bits;
    logic             hit;
    logic [PW-1:0]    hit_pos;
    logic [CW-1:0]    last_chunk;
    logic [CW-1:0]    first_chunk;

    always_comb begin
        base       = int'(c_q) * STEP;
        chunk_bits = w_q[base +: STEP];
        hit        = 1'b0;
        off        = 0;
        // Each later assignment overrides an earlier one. The loop therefore
        // visits the chunk from the far end toward the scan origin, so the
        // bit kept at the end is the one nearest the origin.
        for (int i = 0; i < STEP; i++) begin
            if (d_q) begin
                if (chunk_bits[i]) begin
                    hit = 1'b1;
                    off = i;
                end
            end else begin
                if (chunk_bits[STEP-1-i]) begin
                    hit = 1'b1;
                    off = STEP - 1 - i;
                end
            end
        end
        hit_pos     = PW'(base + off);
        last_chunk  = d_q ? '0 : CW'(NCHUNK - 1);
        first_chunk = dir ? CW'(NCHUNK - 1) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            d_q     <= 1'b0;
            c_q     <= '0;
            v_q     <= 1'b0;
            p_q     <= '0;
        end else begin
`ifdef FFO_SCAN_ABORT_EN
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                v_q     <= 1'b0;
                p_q     <= '0;
            end else
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        w_q     <= b;
                        d_q     <= dir;
                        c_q     <= first_chunk;
                        v_q     <= 1'b0;
                        p_q     <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        v_q     <= 1'b1;
                        p_q     <= hit_pos;
                        state_q <= S_DONE;
                    end else if (c_q == last_chunk) begin
                        v_q     <= 1'b0;
                        p_q     <= '0;
                        state_q <= S_DONE;
                    end else begin
                        c_q <= d_q ? (c_q - CW'(1)) : (c_q + CW'(1));
                    end
                end
                S_DONE: begin
                    // When v=0, "next" has nothing to continue, so it acts
                    // the same as ack.
                    if (ack || (next && !v_q)) begin
                        state_q <= S_IDLE;
                    end else if (next) begin
                        // The search resumes in the chunk of the last hit.
                        // That chunk may still hold more set bits.
                        w_q[p_q] <= 1'b0;
                        state_q  <= S_SCAN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign v         = v_q;
    assign p         = p_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ffo_scan.sv
// tb_ffo_scan: self-checking bench for ffo_scan (WIDTH=32, STEP=4).
// A reference model finds the first set bit by walking the vector index by
// index in scan order. It derives the expected latency from the chunk
// distance between the start chunk and the found bit.
module tb_ffo_scan;

    localparam int WIDTH  = 32;
    localparam int STEP   = 4;
    localparam int PW     = 5;
    localparam int NCHUNK = WIDTH / STEP;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] b;
    logic             dir;
    logic             next;
    logic             ack;
    logic             ready;
    logic             done;
    logic             v;
    logic [PW-1:0]    p;
    logic [1:0]       state_dbg;
`ifdef FFO_SCAN_ABORT_EN
    logic             abort;
`endif

    ffo_scan #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .b         (b),
        .dir       (dir),
        .next      (next),
        .ack       (ack),
`ifdef FFO_SCAN_ABORT_EN
        .abort     (abort),
`endif
        .ready     (ready),
        .done      (done),
        .v         (v),
        .p         (p),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    // Reference model state
    logic [WIDTH-1:0] m_w;
    logic             m_d;
    int               m_c;
    logic             m_v;
    int               m_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Walk the indices in scan order, starting at the origin side of chunk
    // m_c. Push the expected latency, v and p.
    task automatic model_search();
        bit found;
        int q;
        int lat;
        found = 0;
        q     = 0;
        if (!m_d) begin
            for (int i = m_c * STEP; i < WIDTH; i++)
                if (!found && m_w[i]) begin found = 1; q = i; end
        end else begin
            for (int i = m_c * STEP + STEP - 1; i >= 0; i--)
                if (!found && m_w[i]) begin found = 1; q = i; end
        end
        if (found) begin
            lat = ((q / STEP > m_c) ? (q / STEP - m_c) : (m_c - q / STEP)) + 1;
            m_c = q / STEP;
            m_v = 1'b1;
            m_p = q;
        end else begin
            lat = m_d ? (m_c + 1) : (NCHUNK - m_c);
            m_v = 1'b0;
            m_p = 0;
        end
        exp_q.push_back(32'(lat));
        exp_q.push_back({31'd0, m_v});
        exp_q.push_back(32'(m_p));
    endtask

    // Count the edges until done rises (bounded), then check the
    // latency, v and p.
    task automatic wait_result(input string tag);
        int          cnt;
        logic [31:0] e_lat, e_v, e_p;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!done && cnt < 40);
        e_lat = exp_q.pop_front();
        e_v   = exp_q.pop_front();
        e_p   = exp_q.pop_front();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, 32'(cnt), e_lat);
        chk({tag, "_v"}, {31'd0, v}, e_v);
        chk({tag, "_p"}, {27'd0, p}, e_p);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_search(input logic [WIDTH-1:0] bv, input logic dv, input string tag);
        chk({tag, "_ready_pre"}, {31'd0, ready}, 32'd1);
        m_w   = bv;
        m_d   = dv;
        m_c   = dv ? NCHUNK - 1 : 0;
        b     = bv;
        dir   = dv;
        start = 1'b1;
        tick();
        start = 1'b0;
        b     = $urandom;      // must be ignored after the accept edge
        dir   = 1'($urandom);
        chk({tag, "_busy"}, {30'd0, ready, done}, 32'd0);
        model_search();
        wait_result(tag);
    endtask

    task automatic do_next(input string tag);
        m_w[m_p] = 1'b0;
        next  = 1'b1;
        start = 1'b1;          // ignored outside IDLE
        tick();
        next  = 1'b0;
        model_search();
        wait_result(tag);
        start = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_done0"}, {31'd0, done}, 32'd0);
        chk({tag, "_vhold"}, {31'd0, v}, {31'd0, m_v});
        chk({tag, "_phold"}, {27'd0, p}, 32'(m_p));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_seen;
        logic [WIDTH-1:0] rb;

        reset = 1'b1;
        start = 1'b0;
        b     = '0;
        dir   = 1'b0;
        next  = 1'b0;
        ack   = 1'b0;
`ifdef FFO_SCAN_ABORT_EN
        abort = 1'b0;
`endif
        m_w = '0; m_d = 0; m_c = 0; m_v = 0; m_p = 0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_v", {31'd0, v}, 32'd0);
        chk("rst_p", {27'd0, p}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Directed cases: bit 8 scanned upward, then downward
        start_search(32'h0000_0100, 1'b0, "up_bit8");
        do_ack("up_bit8_ack");
        start_search(32'h0000_0100, 1'b1, "dn_bit8");
        do_ack("dn_bit8_ack");

        // Zero vector
        start_search(32'h0000_0000, 1'b0, "zero");
        do_ack("zero_ack");

        // Chained next searches
        start_search(32'h8000_0005, 1'b0, "chain0");
        do_next("chain1");
        do_next("chain2");
        do_next("chain3");
        // When v=0, next acts as ack
        next = 1'b1;
        tick();
        next = 1'b0;
        chk("next_as_ack_ready", {31'd0, ready}, 32'd1);

        // With nothing driven, DONE holds. start is ignored. next+ack -> ack wins.
        start_search(32'h0010_0000, 1'b1, "hold");
        start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0;
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_v", {31'd0, v}, 32'd1);
        chk("hold_p", {27'd0, p}, 32'd20);
        next = 1'b1;
        ack  = 1'b1;
        tick();
        next = 1'b0;
        ack  = 1'b0;
        chk("both_ack_wins", {31'd0, ready}, 32'd1);
        chk("both_p", {27'd0, p}, 32'd20);

        // Chunk boundaries in both directions
        start_search(32'h0000_0001, 1'b1, "dn_bit0");
        do_ack("dn_bit0_ack");
        start_search(32'hF000_0000, 1'b0, "up_top");
        do_next("up_top_n1");
        do_ack("up_top_ack");

        // Random searches
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = 32'd1 << $urandom_range(0, WIDTH - 1);
                2: rb = $urandom & $urandom & $urandom;
                default: rb = $urandom;
            endcase
            start_search(rb, 1'($urandom), $sformatf("rnd%0d", it));
            for (int k = $urandom_range(0, 4); k > 0 && m_v; k--)
                do_next($sformatf("rnd%0d_n%0d", it, k));
            do_ack($sformatf("rnd%0d_ack", it));
        end

        // Reset during SCAN aborts the search
        b     = 32'h8000_0000;
        dir   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_v", {31'd0, v}, 32'd0);
        chk("mid_rst_p", {27'd0, p}, 32'd0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("mid_rst_no_done", 32'(done_seen), 32'd0);
        m_v = 0;
        m_p = 0;
        start_search(32'h0000_0010, 1'b0, "post_rst");
        do_ack("post_rst_ack");

`ifdef FFO_SCAN_ABORT_EN
        // Abort during SCAN
        done_seen = 0;
        b     = 32'h8000_0000;
        dir   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        if (done) done_seen++;
        tick();
        if (done) done_seen++;
        abort = 1'b1;
        next  = 1'b1;
        tick();
        abort = 1'b0;
        next  = 1'b0;
        if (done) done_seen++;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_v", {31'd0, v}, 32'd0);
        chk("abort_p", {27'd0, p}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        // Abort in DONE drops the result. Abort in IDLE is harmless.
        start_search(32'h0000_0004, 1'b0, "abort_done");
        abort = 1'b1;
        tick();
        chk("abort_in_done_ready", {31'd0, ready}, 32'd1);
        chk("abort_in_done_v", {31'd0, v}, 32'd0);
        tick();
        abort = 1'b0;
        chk("abort_idle_ready", {31'd0, ready}, 32'd1);
        m_v = 0;
        m_p = 0;
        start_search(32'h0000_0200, 1'b1, "after_abort");
        do_ack("after_abort_ack");
`endif

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
